// File: rtl/de2_i2c_pkg.sv
// Shared constants for the DE2 I2C target: FSM state encodings and bus-level bit meanings.
package de2_i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ADDR     = 4'd1;
    localparam state_t ST_ACK_ADDR = 4'd2;
    localparam state_t ST_SUB      = 4'd3;
    localparam state_t ST_ACK_SUB  = 4'd4;
    localparam state_t ST_WR       = 4'd5;
    localparam state_t ST_ACK_WR   = 4'd6;
    localparam state_t ST_RD       = 4'd7;
    localparam state_t ST_RACK     = 4'd8;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;
    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;

endpackage

// File: rtl/de2_i2c_line_sync.sv
// Two-flop synchronizer for one I2C line plus a history flop for rise/fall detection.
module de2_i2c_line_sync (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic i_line,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // shift the pin through the synchronizer and history stages
    always_comb begin
        sync_d = {sync_q[1:0], i_line};
    end

    // idle bus is high, so reset to 1 to avoid a spurious edge after reset
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign o_lvl  = sync_q[1];
    assign o_rise = sync_q[1] & ~sync_q[2];
    assign o_fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/de2_i2c_target_regfile.sv
// I2C target with a byte register file: address match, sub-address pointer, write bursts, reads via repeated START.
module de2_i2c_target_regfile
    import de2_i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned REG_AW   = 6,
    parameter logic [7:0]  RST_VAL  = 8'h00
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              I2C_SCLK,
    inout  wire               I2C_SDAT,
    output logic              oWR_STB,
    output logic [REG_AW-1:0] oWR_ADDR,
    output logic [7:0]        oWR_DATA,
    input  logic [REG_AW-1:0] iRD_ADDR,
    output logic [7:0]        oRD_DATA,
    output logic              oBUSY
);

    localparam int unsigned DEPTH = 1 << REG_AW;

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] rx_byte_s;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              busy_q, busy_d;
    logic              sda_oe_q, sda_oe_d;
    logic              ack_drv_q, ack_drv_d;
    logic              rw_q, rw_d;
    logic              wr_stb_q, wr_stb_d;
    logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];

    de2_i2c_line_sync u_scl_sync (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_line (I2C_SCLK),
        .o_lvl  (scl_lvl_s),
        .o_rise (scl_rise_s),
        .o_fall (scl_fall_s)
    );

    de2_i2c_line_sync u_sda_sync (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .i_line (I2C_SDAT),
        .o_lvl  (sda_lvl_s),
        .o_rise (sda_rise_s),
        .o_fall (sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_lvl_s;
    assign stop_s    = sda_rise_s & scl_lvl_s;
    assign rx_byte_s = {shift_q[6:0], sda_lvl_s};

    // open-drain: only ever pull low or release
    assign I2C_SDAT = sda_oe_q ? 1'b0 : 1'bz;

    // bus FSM: START/STOP override everything, otherwise advance on synchronized SCL edges
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        sda_oe_d  = sda_oe_q;
        ack_drv_d = ack_drv_q;
        rw_d      = rw_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_d     = mem_q;
        rd_data_d = mem_q[iRD_ADDR];

        if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
        end else if (stop_s) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            ack_drv_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ADDR, ST_SUB, ST_WR: begin
                    if (scl_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            ack_drv_d = 1'b0;
                            case (state_q)
                                ST_ADDR: begin
                                    if (rx_byte_s[7:1] == DEV_ADDR) begin
                                        state_d = ST_ACK_ADDR;
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte_s[0];
                                    end else begin
                                        state_d = ST_IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                ST_SUB: begin
                                    ptr_d   = rx_byte_s[REG_AW-1:0];
                                    state_d = ST_ACK_SUB;
                                end
                                default: begin
                                    mem_d[ptr_q] = rx_byte_s;
                                    wr_stb_d     = 1'b1;
                                    wr_addr_d    = ptr_q;
                                    wr_data_d    = rx_byte_s;
                                    ptr_d        = ptr_q + REG_AW'(1'b1);
                                    state_d      = ST_ACK_WR;
                                end
                            endcase
                        end else begin
                            ack_drv_d = 1'b0;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_ACK_ADDR, ST_ACK_SUB, ST_ACK_WR: begin
                    // first falling edge starts the ACK, second one ends it
                    if (scl_fall_s) begin
                        if (!ack_drv_q) begin
                            ack_drv_d = 1'b1;
                            sda_oe_d  = (ACK == 1'b0);
                        end else begin
                            ack_drv_d = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            case (state_q)
                                ST_ACK_ADDR: begin
                                    if (rw_q == I2C_RD) begin
                                        state_d   = ST_RD;
                                        shift_d   = mem_q[ptr_q];
                                        sda_oe_d  = ~mem_q[ptr_q][7];
                                        bit_cnt_d = 4'd1;
                                    end else begin
                                        state_d = ST_SUB;
                                    end
                                end
                                default: begin
                                    state_d = ST_WR;
                                end
                            endcase
                        end
                    end else begin
                        ack_drv_d = ack_drv_q;
                    end
                end
                ST_RD: begin
                    // bit_cnt counts bits already placed on the bus; 0 means load the next byte
                    if (scl_fall_s) begin
                        if (bit_cnt_q == 4'd0) begin
                            shift_d   = mem_q[ptr_q];
                            sda_oe_d  = ~mem_q[ptr_q][7];
                            bit_cnt_d = 4'd1;
                        end else if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + REG_AW'(1'b1);
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                ST_RACK: begin
                    if (scl_rise_s) begin
                        if (sda_lvl_s == ACK) begin
                            state_d   = ST_RD;
                            bit_cnt_d = 4'd0;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        state_d = ST_RACK;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                    busy_d   = 1'b0;
                end
            endcase
        end
    end

    // FSM, datapath and output registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            ack_drv_q <= 1'b0;
            rw_q      <= I2C_WR;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            sda_oe_q  <= sda_oe_d;
            ack_drv_q <= ack_drv_d;
            rw_q      <= rw_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_data_q <= rd_data_d;
        end
    end

    // register file storage
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign oWR_STB  = wr_stb_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oRD_DATA = rd_data_q;
    assign oBUSY    = busy_q;

endmodule

// File: tb/tb_de2_i2c_target_regfile.sv
// Directed bench for de2_i2c_target_regfile: bit-banged I2C master, write-strobe scoreboard, host read-back.
module tb_de2_i2c_target_regfile;

    localparam int Q = 6;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       scl       = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic       wr_stb;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr   = 6'd0;
    logic [7:0] rd_data;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int z_viol       = 0;
    int busy_viol    = 0;
    logic watch_z    = 1'b0;

    logic [13:0] exp_q [$];
    logic [7:0]  model [64];

    assign sda = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    de2_i2c_target_regfile dut (
        .iCLK     (clk),
        .iRST_N   (rst_n),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda),
        .oWR_STB  (wr_stb),
        .oWR_ADDR (wr_addr),
        .oWR_DATA (wr_data),
        .iRD_ADDR (rd_addr),
        .oRD_DATA (rd_data),
        .oBUSY    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // strobe scoreboard and bus watchers
    always @(negedge clk) begin
        logic [14:0] e;
        if (wr_stb === 1'b1) begin
            e = (exp_q.size() > 0) ? {1'b1, exp_q.pop_front()} : 15'h0000;
            tests_run++;
            assert ({1'b1, wr_addr, wr_data} === e) else begin
                tests_failed++;
                $error("FAIL wr_strobe: observed %0h expected %0h", {1'b1, wr_addr, wr_data}, e);
            end
        end
        if (watch_z && !m_sda_low && sda !== 1'b1) z_viol++;
        if (watch_z && busy !== 1'b0) busy_viol++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
        model[a] = d;
    endtask

    task automatic wbit(input logic b);
        m_sda_low = ~b; qw();
        scl = 1'b1; qw(); qw();
        scl = 1'b0; qw();
    endtask

    task automatic rbit(output logic b);
        m_sda_low = 1'b0; qw();
        scl = 1'b1; qw();
        b = sda; qw();
        scl = 1'b0; qw();
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic mack);
        for (int i = 7; i >= 0; i--) rbit(d[i]);
        wbit(mack);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; qw();
        scl = 1'b1; qw();
        m_sda_low = 1'b1; qw();
        scl = 1'b0; qw();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; qw();
        scl = 1'b1; qw();
        m_sda_low = 1'b0; qw(); qw();
    endtask

    task automatic host_read(input string tag, input logic [5:0] a);
        rd_addr = a;
        @(posedge clk); #1;
        check(tag, rd_data, model[a]);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        for (int i = 0; i < 64; i++) model[i] = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_stb", wr_stb, 1'b0);
        check("rst_waddr", wr_addr, 6'd0);
        check("rst_wdata", wr_data, 8'h00);
        check("rst_rdata", rd_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_sda", sda, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single write
        i2c_start();
        wbyte(8'h34, ack); check("t1_ack_addr", ack, 1'b0);
        check("t1_busy", busy, 1'b1);
        wbyte(8'h08, ack); check("t1_ack_sub", ack, 1'b0);
        push_wr(6'h08, 8'hF8);
        wbyte(8'hF8, ack); check("t1_ack_data", ack, 1'b0);
        i2c_stop();
        check("t1_busy_after_stop", busy, 1'b0);
        host_read("t1_read08", 6'h08);

        // 2: address mismatch
        watch_z = 1'b1;
        i2c_start();
        wbyte(8'h40, ack); check("t2_nack_addr", ack, 1'b1);
        wbyte(8'h55, ack); check("t2_nack_data", ack, 1'b1);
        i2c_stop();
        watch_z = 1'b0;
        check("t2_sda_z", z_viol, 0);
        check("t2_busy_low", busy_viol, 0);

        // 3: burst with pointer wrap
        i2c_start();
        wbyte(8'h34, ack); check("t3_ack_addr", ack, 1'b0);
        wbyte(8'h3E, ack); check("t3_ack_sub", ack, 1'b0);
        push_wr(6'h3E, 8'h11); wbyte(8'h11, ack); check("t3_ack_d0", ack, 1'b0);
        push_wr(6'h3F, 8'h22); wbyte(8'h22, ack); check("t3_ack_d1", ack, 1'b0);
        push_wr(6'h00, 8'h33); wbyte(8'h33, ack); check("t3_ack_d2", ack, 1'b0);
        i2c_stop();
        host_read("t3_read3E", 6'h3E);
        host_read("t3_read3F", 6'h3F);
        host_read("t3_read00", 6'h00);

        // 4: preload 10/11, then set pointer, repeated START, read two bytes
        i2c_start();
        wbyte(8'h34, ack); wbyte(8'h10, ack);
        push_wr(6'h10, 8'hA5); wbyte(8'hA5, ack);
        push_wr(6'h11, 8'h5A); wbyte(8'h5A, ack); check("t4_ack_pre", ack, 1'b0);
        i2c_stop();
        i2c_start();
        wbyte(8'h34, ack); check("t4_ack_waddr", ack, 1'b0);
        wbyte(8'h10, ack); check("t4_ack_sub", ack, 1'b0);
        i2c_start();
        wbyte(8'h35, ack); check("t4_ack_raddr", ack, 1'b0);
        rbyte(d, 1'b0); check("t4_rd0", d, model[6'h10]);
        rbyte(d, 1'b1); check("t4_rd1", d, model[6'h11]);
        repeat (4) @(negedge clk);
        check("t4_sda_released", sda, 1'b1);
        check("t4_busy_after_nack", busy, 1'b0);
        i2c_stop();

        // 5: STOP after 5 bits of a data byte
        i2c_start();
        wbyte(8'h34, ack); wbyte(8'h20, ack); check("t5_ack_sub", ack, 1'b0);
        d = 8'hFF;
        for (int i = 7; i >= 3; i--) wbit(d[i]);
        i2c_stop();
        host_read("t5_read20_unchanged", 6'h20);
        i2c_start();
        wbyte(8'h34, ack); wbyte(8'h20, ack);
        push_wr(6'h20, 8'hC3); wbyte(8'hC3, ack); check("t5_ack_data", ack, 1'b0);
        i2c_stop();
        host_read("t5_read20", 6'h20);

        // 6: async reset during the data ACK
        i2c_start();
        wbyte(8'h34, ack); wbyte(8'h05, ack);
        push_wr(6'h05, 8'h7E);
        d = 8'h7E;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        m_sda_low = 1'b0; qw();
        check("t6_ack_driven", sda, 1'b0);
        scl = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_sda_async_z", sda, 1'b1);
        check("t6_busy_async", busy, 1'b0);
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        qw();
        scl = 1'b0; qw();
        i2c_stop();
        host_read("t6_read05_reset", 6'h05);
        host_read("t6_read08_reset", 6'h08);
        i2c_start();
        wbyte(8'h34, ack); check("t6_ack_addr_after", ack, 1'b0);
        wbyte(8'h07, ack);
        push_wr(6'h07, 8'h99); wbyte(8'h99, ack); check("t6_ack_data_after", ack, 1'b0);
        i2c_stop();
        host_read("t6_read07", 6'h07);

        repeat (4) @(negedge clk);
        check("strobes_outstanding", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
